alu_share_arbiter: RTL and testbench

- Shares one combinational `alu` instance between two requesters.
  - Port 0: the EX-stage integer pipe.
  - Port 1: the auxiliary unit, e.g. branch-target or address generation.
- Drives the ALU operand/opcode inputs, samples its result and zero flag in the same cycle, and returns a registered response to the winning requester.
- Arbitration is round-robin, or fixed priority with an anti-starvation limit.
- Each port's response path has its own one-entry skid register.

---
 rtl/alu_share_arbiter_if.sv | 56 +++++
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles the two requester ports, the two response ports and the ALU
//   drive/return signals of alu_share_arbiter.
//   slave  : the arbiter side (consumes requests, produces responses and ALU drive).
//   master : the environment side (requesters, response consumers, the ALU).
//   Parameters: DATA_W operand/result width, OP_W ALU control width.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_zero;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_zero;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    output rsp1_valid, rsp1_result, rsp1_zero,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp1_valid, rsp1_result, rsp1_zero,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters (port 0: EX pipe,
//   port 1: auxiliary unit). The winner's operands drive the ALU, the ALU
//   result is captured the same cycle into that port's one-entry response
//   register, so responses appear exactly one cycle after acceptance.
//   Arbitration: round-robin (FIXED_PRIO=0) or port 0 priority with a
//   starvation override for port 1 after STARVE_LIMIT lost arbitrations.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   bus (slave)   : request, response and ALU signals (alu_share_arbiter_if)
//   stat_*        : 16-bit wrapping grant/conflict counters, present only
//                   when the macro ALU_ARB_STATS_EN is defined
module alu_share_arbiter #(
  parameter int DATA_W       = 32,
  parameter int OP_W         = 4,
  parameter int FIXED_PRIO   = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0] stat_grant0,
  output logic [15:0] stat_grant1,
  output logic [15:0] stat_conflict
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              rsp0_valid_q;
  logic [DATA_W-1:0] rsp0_result_q;
  logic              rsp0_zero_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] rsp1_result_q;
  logic              rsp1_zero_q;
  logic              last_grant;
  logic [3:0]        starve_cnt;

  logic elig0;
  logic elig1;
  logic prefer1;
  logic grant0;
  logic grant1;

  // A slot is free when empty or being drained this very cycle; ready is
  // forced low while reset is asserted.
  assign elig0 = rst_n & bus.req0_valid & (~rsp0_valid_q | bus.rsp0_ready);
  assign elig1 = rst_n & bus.req1_valid & (~rsp1_valid_q | bus.rsp1_ready);

  always_comb begin
    prefer1 = 1'b0;
    if (FIXED_PRIO != 0) begin
      prefer1 = (starve_cnt == LIMIT);
    end else begin
      prefer1 = ~last_grant;
    end
    grant1 = elig1 & (~elig0 | prefer1);
    grant0 = elig0 & ~grant1;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Idle cycles keep the port-0 operands on the ALU to avoid needless toggling.
  assign bus.alu_a    = grant1 ? bus.req1_a  : bus.req0_a;
  assign bus.alu_b    = grant1 ? bus.req1_b  : bus.req0_b;
  assign bus.alu_ctrl = grant1 ? bus.req1_op : bus.req0_op;

  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp0_result = rsp0_result_q;
  assign bus.rsp0_zero   = rsp0_zero_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp1_result = rsp1_result_q;
  assign bus.rsp1_zero   = rsp1_zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
      last_grant    <= 1'b1;
      starve_cnt    <= 4'd0;
    end else begin
      if (grant0) begin
        rsp0_valid_q  <= 1'b1;
        rsp0_result_q <= bus.alu_result;
        rsp0_zero_q   <= bus.alu_zero;
      end else if (bus.rsp0_ready) begin
        rsp0_valid_q  <= 1'b0;
      end

      if (grant1) begin
        rsp1_valid_q  <= 1'b1;
        rsp1_result_q <= bus.alu_result;
        rsp1_zero_q   <= bus.alu_zero;
      end else if (bus.rsp1_ready) begin
        rsp1_valid_q  <= 1'b0;
      end

      if (grant0 | grant1) begin
        last_grant <= grant1;
      end

      // Only an eligible-but-losing port 1 counts as starved; a blocked
      // slot does not.
      if (FIXED_PRIO != 0) begin
        if (grant1) begin
          starve_cnt <= 4'd0;
        end else if (elig1 && starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grant0   <= 16'd0;
      stat_grant1   <= 16'd0;
      stat_conflict <= 16'd0;
    end else begin
      if (grant0) begin
        stat_grant0 <= stat_grant0 + 16'd1;
      end
      if (grant1) begin
        stat_grant1 <= stat_grant1 + 16'd1;
      end
      if (elig0 & elig1) begin
        stat_conflict <= stat_conflict + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_W(32), .OP_W(4)) ifa ();
  alu_share_arbiter_if #(.DATA_W(32), .OP_W(4)) ifb ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] sa_g0, sa_g1, sa_cf, sb_g0, sb_g1, sb_cf;
`endif

  alu_share_arbiter #(.DATA_W(32), .OP_W(4), .FIXED_PRIO(0), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ifa)
`ifdef ALU_ARB_STATS_EN
    , .stat_grant0(sa_g0), .stat_grant1(sa_g1), .stat_conflict(sa_cf)
`endif
  );

  alu_share_arbiter #(.DATA_W(32), .OP_W(4), .FIXED_PRIO(1), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ifb)
`ifdef ALU_ARB_STATS_EN
    , .stat_grant0(sb_g0), .stat_grant1(sb_g1), .stat_conflict(sb_cf)
`endif
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Environment-side ALU models
  assign ifa.alu_result = alu_f(ifa.alu_a, ifa.alu_b, ifa.alu_ctrl);
  assign ifa.alu_zero   = (alu_f(ifa.alu_a, ifa.alu_b, ifa.alu_ctrl) == 32'd0);
  assign ifb.alu_result = alu_f(ifb.alu_a, ifb.alu_b, ifb.alu_ctrl);
  assign ifb.alu_zero   = (alu_f(ifb.alu_a, ifb.alu_b, ifb.alu_ctrl) == 32'd0);

  typedef struct {
    bit         rst;
    bit         v0;
    logic [3:0] op0;
    logic [31:0] a0;
    logic [31:0] b0;
    bit         v1;
    logic [3:0] op1;
    logic [31:0] a1;
    logic [31:0] b1;
    bit         rr0;
    bit         rr1;
    bit         er0;
    bit         er1;
    bit         ev0;
    bit         ev1;
  } vec_t;

  vec_t vecs[$];
  logic [32:0] sb0[$];
  logic [32:0] sb1[$];
  int errors = 0;
  int checks = 0;
  bit hold0 = 0, hold1 = 0, after_rst = 0;
  logic [32:0] hv0, hv1;

  function automatic vec_t mk(input bit rst,
                              input bit v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                              input bit v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                              input bit rr0, input bit rr1,
                              input bit er0, input bit er1, input bit ev0, input bit ev1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.rr0 = rr0; v.rr1 = rr1; v.er0 = er0; v.er1 = er1; v.ev0 = ev0; v.ev1 = ev1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector into dut_a right after a falling edge, check and
  // update the scoreboard at +1, then move to the next falling edge.
  task automatic apply(input vec_t v, input int idx);
    logic [32:0] e;
    rst_a = ~v.rst;
    ifa.req0_valid = v.v0; ifa.req0_op = v.op0; ifa.req0_a = v.a0; ifa.req0_b = v.b0;
    ifa.req1_valid = v.v1; ifa.req1_op = v.op1; ifa.req1_a = v.a1; ifa.req1_b = v.b1;
    ifa.rsp0_ready = v.rr0; ifa.rsp1_ready = v.rr1;
    #1;
    chk($sformatf("row%0d_req0_ready", idx), 64'(ifa.req0_ready), 64'(v.er0));
    chk($sformatf("row%0d_req1_ready", idx), 64'(ifa.req1_ready), 64'(v.er1));
    chk($sformatf("row%0d_rsp0_valid", idx), 64'(ifa.rsp0_valid), 64'(v.ev0));
    chk($sformatf("row%0d_rsp1_valid", idx), 64'(ifa.rsp1_valid), 64'(v.ev1));
    if (after_rst) begin
      chk($sformatf("row%0d_rsp0_cleared", idx), 64'({ifa.rsp0_zero, ifa.rsp0_result}), 64'd0);
      chk($sformatf("row%0d_rsp1_cleared", idx), 64'({ifa.rsp1_zero, ifa.rsp1_result}), 64'd0);
    end
    if (hold0) begin
      chk($sformatf("row%0d_hold0", idx), 64'({ifa.rsp0_valid, ifa.rsp0_zero, ifa.rsp0_result}),
          64'({1'b1, hv0}));
    end
    if (hold1) begin
      chk($sformatf("row%0d_hold1", idx), 64'({ifa.rsp1_valid, ifa.rsp1_zero, ifa.rsp1_result}),
          64'({1'b1, hv1}));
    end
    if (!v.rst) begin
      if (ifa.rsp0_valid && v.rr0) begin
        if (sb0.size() == 0) chk($sformatf("row%0d_sb0_unexpected", idx), 64'(1), 64'(0));
        else begin
          e = sb0.pop_front();
          chk($sformatf("row%0d_rsp0_data", idx), 64'({ifa.rsp0_zero, ifa.rsp0_result}), 64'(e));
        end
      end
      if (ifa.rsp1_valid && v.rr1) begin
        if (sb1.size() == 0) chk($sformatf("row%0d_sb1_unexpected", idx), 64'(1), 64'(0));
        else begin
          e = sb1.pop_front();
          chk($sformatf("row%0d_rsp1_data", idx), 64'({ifa.rsp1_zero, ifa.rsp1_result}), 64'(e));
        end
      end
      if (v.v0 && ifa.req0_ready) begin
        e[31:0] = alu_f(v.a0, v.b0, v.op0);
        e[32] = (e[31:0] == 32'd0);
        sb0.push_back(e);
      end
      if (v.v1 && ifa.req1_ready) begin
        e[31:0] = alu_f(v.a1, v.b1, v.op1);
        e[32] = (e[31:0] == 32'd0);
        sb1.push_back(e);
      end
    end
    hold0 = !v.rst && ifa.rsp0_valid && !v.rr0;
    hold1 = !v.rst && ifa.rsp1_valid && !v.rr1;
    hv0 = {ifa.rsp0_zero, ifa.rsp0_result};
    hv1 = {ifa.rsp1_zero, ifa.rsp1_result};
    if (v.rst) begin
      sb0.delete();
      sb1.delete();
    end
    after_rst = v.rst;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.req0_valid = 0; ifa.req0_a = 0; ifa.req0_b = 0; ifa.req0_op = 0;
    ifa.req1_valid = 0; ifa.req1_a = 0; ifa.req1_b = 0; ifa.req1_op = 0;
    ifa.rsp0_ready = 1; ifa.rsp1_ready = 1;
    ifb.req0_valid = 0; ifb.req0_a = 0; ifb.req0_b = 0; ifb.req0_op = 0;
    ifb.req1_valid = 0; ifb.req1_a = 0; ifb.req1_b = 0; ifb.req1_op = 0;
    ifb.rsp0_ready = 1; ifb.rsp1_ready = 1;

    // rst v0 op a b | v1 op a b | rr0 rr1 | er0 er1 | ev0 ev1
    vecs.push_back(mk(0, 1, OP_ADD, 5, 7,       0, OP_ADD, 0, 0,          1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_SUB, 3, 3,       1, OP_XOR, 'hF0, 'h0F,    1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_SUB, 3, 3,       1, OP_XOR, 'hF0, 'h0F,    1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, OP_SUB, 3, 3,       1, OP_XOR, 'hF0, 'h0F,    1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, OP_SUB, 3, 3,       1, OP_XOR, 'hF0, 'h0F,    1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, OP_ADD, 1, 1,       0, OP_ADD, 0, 0,          0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_ADD, 2, 2,       1, OP_OR, 'h30, 'h03,     0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, OP_ADD, 2, 2,       1, OP_OR, 'h30, 'h03,     0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, OP_ADD, 2, 2,       1, OP_OR, 'h30, 'h03,     0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, OP_ADD, 2, 2,       1, OP_OR, 'h30, 'h03,     1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       1, OP_OR, 'h30, 'h03,     1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       1, OP_AND, 'hFF, 'h0F,    1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, OP_ADD, 9, 1,       1, OP_SUB, 9, 1,          1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_ADD, 9, 1,       1, OP_SUB, 9, 1,          1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_ADD, 1, 2,       0, OP_ADD, 0, 0,          1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_ADD, 3, 4,       0, OP_ADD, 0, 0,          1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, OP_XOR, 7, 7,       0, OP_ADD, 0, 0,          1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_ADD, 6, 6,       1, OP_ADD, 8, 8,          1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 0));
    // Reset, then 10 cycles of dual requests under round-robin
    vecs.push_back(mk(1, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk(0, 1, OP_ADD, 32'(k), 32'(100), 1, OP_SUB, 32'(k), 32'(k),
                        1, 1, (k % 2) == 0, (k % 2) == 1, (k % 2) == 1, (k > 0) && ((k % 2) == 0)));
    end
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0,       0, OP_ADD, 0, 0,          1, 1, 0, 0, 0, 0));

    // Initial reset of dut_a
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_ready", 64'({ifa.req0_ready, ifa.req1_ready}), 64'd0);
    chk("reset_rsp0", 64'({ifa.rsp0_valid, ifa.rsp0_zero, ifa.rsp0_result}), 64'd0);
    chk("reset_rsp1", 64'({ifa.rsp1_valid, ifa.rsp1_zero, ifa.rsp1_result}), 64'd0);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end
    chk("sb0_drained", 64'(sb0.size()), 64'd0);
    chk("sb1_drained", 64'(sb1.size()), 64'd0);

`ifdef ALU_ARB_STATS_EN
    chk("stat_grant0", 64'(sa_g0), 64'd5);
    chk("stat_grant1", 64'(sa_g1), 64'd5);
    chk("stat_conflict", 64'(sa_cf), 64'd10);
`endif

    // Fixed priority with starvation limit 4 on dut_b
    rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    ifb.req0_valid = 1; ifb.req0_op = OP_ADD; ifb.req0_a = 1; ifb.req0_b = 1;
    ifb.req1_valid = 1; ifb.req1_op = OP_SUB; ifb.req1_a = 5; ifb.req1_b = 2;
    ifb.rsp0_ready = 1; ifb.rsp1_ready = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("prio_c%0d_req0_ready", c), 64'(ifb.req0_ready), 64'(!(c == 4 || c == 9)));
      chk($sformatf("prio_c%0d_req1_ready", c), 64'(ifb.req1_ready), 64'(c == 4 || c == 9));
      if (c == 5) begin
        chk("prio_rsp1", 64'({ifb.rsp1_valid, ifb.rsp1_zero, ifb.rsp1_result}), 64'({2'b10, 32'd3}));
      end
      if (c == 1) begin
        chk("prio_rsp0", 64'({ifb.rsp0_valid, ifb.rsp0_zero, ifb.rsp0_result}), 64'({2'b10, 32'd2}));
      end
      @(negedge clk);
    end
    ifb.req0_valid = 0;
    ifb.req1_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
